// File: rtl/barrel_shifter_32.sv
// 32-bit logical barrel shifter with a registered result.
// Left shifts reuse the right-shift network by bit-reversing the operand and the result.
module barrel_shifter_32 (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] D,
   input  logic [4:0]  S,
   input  logic        LnR,
   output logic [31:0] Y
);

   logic [31:0] d_rev;
   logic [31:0] net_rev;
   logic [31:0] stage [0:5];
   logic [31:0] y_d;
   logic [31:0] y_q;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign d_rev[gi]   = D[31-gi];
         assign net_rev[gi] = stage[5][31-gi];
      end
   endgenerate

   assign stage[0] = LnR ? d_rev : D;

   // Stage gi shifts right by 2**gi with zero fill when S[gi] is set.
   generate
      for (gi = 0; gi < 5; gi++) begin : g_stage
         localparam int SH = 1 << gi;
         assign stage[gi+1] = S[gi] ? {{SH{1'b0}}, stage[gi][31:SH]} : stage[gi];
      end
   endgenerate

   assign y_d = LnR ? net_rev : stage[5];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign Y = y_q;

endmodule

// File: tb/tb_barrel_shifter_32.sv
// Randomized self-checking bench for barrel_shifter_32 against a shift-operator model.
// A negedge compare process checks every cycle; literal vectors pin the model.
module tb_barrel_shifter_32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] d = '0;
   logic [4:0]  s = '0;
   logic        lnr = 1'b0;
   logic [31:0] y;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic [31:0] exp_y = '0;

   barrel_shifter_32 dut (
      .CLK(clk),
      .RST(rst_n),
      .D  (d),
      .S  (s),
      .LnR(lnr),
      .Y  (y)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_shift(input logic [31:0] dv, input logic [4:0] sv,
                                             input logic lv);
      logic [31:0] r;
      r = lv ? (dv << sv) : (dv >> sv);
      return r;
   endfunction

   // Expected output: result of the inputs seen at the last edge, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_y <= '0;
      else        exp_y <= ref_shift(d, s, lnr);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (y !== exp_y) begin
            errors++;
            $display("FAIL cycle_model: Y=%08h expected=%08h", y, exp_y);
         end
      end
   end

   task automatic check_now(input string name, input logic [31:0] want);
      checks++;
      if (y !== want) begin
         errors++;
         $display("FAIL %s: Y=%08h expected=%08h", name, y, want);
      end else begin
         $display("ok %s: Y=%08h", name, y);
      end
   endtask

   // Called at posedge+#1: drive a vector, take one edge, check against a literal.
   task automatic lit(input string name, input logic [31:0] dv, input logic [4:0] sv,
                      input logic lv, input logic [31:0] want);
      d = dv; s = sv; lnr = lv;
      @(posedge clk); #1;
      check_now(name, want);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      check_now("reset_state", 32'h0);
      @(posedge clk); @(posedge clk); #1;
      check_now("reset_hold", 32'h0);
      rst_n = 1'b1;

      lit("dir_s1_left",   32'h00000001, 5'd1,  1'b1, 32'h00000002);
      lit("dir_s1_right",  32'h00000001, 5'd1,  1'b0, 32'h00000000);
      lit("dir_s2_left",   32'h00000001, 5'd2,  1'b1, 32'h00000004);
      lit("dir_s2_right",  32'h00000001, 5'd2,  1'b0, 32'h00000000);
      lit("fill_right5",   32'hffffffff, 5'd5,  1'b0, 32'h07ffffff);
      lit("trunc_left15",  32'hffffffff, 5'd15, 1'b1, 32'hffff8000);
      lit("s0_left",       32'hffffffff, 5'd0,  1'b1, 32'hffffffff);
      lit("s0_right",      32'hffffffff, 5'd0,  1'b0, 32'hffffffff);
      lit("mix_r31",       32'h198af7b1, 5'd31, 1'b0, 32'h00000000);
      lit("mix_l17",       32'h101f568a, 5'd17, 1'b1, 32'had140000);
      lit("mix_r20",       32'h9078af1b, 5'd20, 1'b0, 32'h00000907);
      lit("mix_l4",        32'h7811bf90, 5'd4,  1'b1, 32'h811bf900);
      lit("s31_left",      32'h00000001, 5'd31, 1'b1, 32'h80000000);
      lit("s31_right",     32'h80000000, 5'd31, 1'b0, 32'h00000001);

      // Back-to-back vectors with mid-cycle glitches that must not reach Y.
      for (int i = 0; i < 200; i++) begin
         d = $urandom; s = 5'($urandom_range(31)); lnr = 1'($urandom_range(1));
         #2;
         d = $urandom; s = 5'($urandom_range(31)); lnr = 1'($urandom_range(1));
         @(posedge clk); #1;
      end

      // Every S/LnR combination for several random operands.
      for (int t = 0; t < 4; t++) begin
         logic [31:0] dv;
         dv = $urandom;
         for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 32; k++) begin
               d = dv; s = 5'(k); lnr = 1'(l);
               @(posedge clk); #1;
            end
         end
      end

      // Asynchronous reset between edges, hold, then release.
      d = 32'hffffffff; s = 5'd0; lnr = 1'b1;
      @(posedge clk); #1;
      check_now("pre_reset_ones", 32'hffffffff);
      #2 rst_n = 1'b0;
      #1 check_now("async_reset", 32'h0);
      @(posedge clk); @(posedge clk); #1;
      check_now("reset_held_edges", 32'h0);
      d = 32'h0000f00d; s = 5'd8; lnr = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_now("release_load", 32'h00f00d00);

      for (int i = 0; i < 50; i++) begin
         d = $urandom; s = 5'($urandom_range(31)); lnr = 1'($urandom_range(1));
         if (i == 25) begin
            #2 rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end

      @(negedge clk);
      #1 chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
